// File: rtl/cfg_frame_sequencer_pkg.sv
// Shared types and header field layout for the configuration frame sequencer.
// The arbiter, the interface and the top-level FSM all import this package.
package cfg_frame_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HEADER = 2'd1,
        ST_DATA   = 2'd2,
        ST_COMMIT = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        OWN_NONE = 2'b00,
        OWN_BB   = 2'b01,
        OWN_UART = 2'b10
    } owner_t;

    localparam int HDR_COL_MSB = 31;
    localparam int HDR_COL_LSB = 24;
    localparam int HDR_IDX_MSB = 23;
    localparam int HDR_IDX_LSB = 16;
    localparam int HDR_CNT_MSB = 15;
    localparam int HDR_CNT_LSB = 0;

    // A single-row frame still needs a one-bit row index.
    function automatic int row_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/cfg_frame_sequencer_if.sv
// Bundles the two config-source inputs and the frame-write outputs.
// Signal directions are named from the sequencer's point of view.
interface cfg_frame_sequencer_if
    import cfg_frame_sequencer_pkg::*;
#(
    parameter int NUM_ROWS = 16
);
    localparam int ROW_W = row_width(NUM_ROWS);

    logic             i_bb_active;
    logic             i_bb_strobe;
    logic [31:0]      i_bb_data;
    logic             i_uart_active;
    logic             i_uart_strobe;
    logic [31:0]      i_uart_data;
    logic [31:0]      o_frame_data;
    logic [ROW_W-1:0] o_frame_row;
    logic             o_frame_we;
    logic [7:0]       o_frame_col;
    logic [7:0]       o_frame_idx;
    logic             o_frame_commit;
    logic [1:0]       o_owner;
    logic             o_busy;
    logic             o_cfg_err;

    modport slave (
        input  i_bb_active, i_bb_strobe, i_bb_data,
        input  i_uart_active, i_uart_strobe, i_uart_data,
        output o_frame_data, o_frame_row, o_frame_we, o_frame_col, o_frame_idx,
        output o_frame_commit, o_owner, o_busy, o_cfg_err
    );

    modport master (
        output i_bb_active, i_bb_strobe, i_bb_data,
        output i_uart_active, i_uart_strobe, i_uart_data,
        input  o_frame_data, o_frame_row, o_frame_we, o_frame_col, o_frame_idx,
        input  o_frame_commit, o_owner, o_busy, o_cfg_err
    );

endinterface

// File: rtl/cfg_src_arbiter.sv
// Grants the sequencer to one config source and holds it until that source's
// session ends; also muxes the owner's strobe and data for the FSM.
module cfg_src_arbiter
    import cfg_frame_sequencer_pkg::*;
(
    input  logic        clk,
    input  logic        resetn,
    input  logic        i_bb_active,
    input  logic        i_bb_strobe,
    input  logic [31:0] i_bb_data,
    input  logic        i_uart_active,
    input  logic        i_uart_strobe,
    input  logic [31:0] i_uart_data,
    output owner_t      o_owner,
    output logic        o_busy,
    output logic        o_grant,
    output logic        o_owner_active,
    output logic        o_strobe,
    output logic [31:0] o_data
);

    owner_t r_owner;
    logic   r_busy;

    // Releasing always passes through OWN_NONE for a cycle before any re-grant.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_owner <= OWN_NONE;
            r_busy  <= 1'b0;
        end else begin
            case (r_owner)
                OWN_NONE: begin
                    if (i_bb_active) begin
                        r_owner <= OWN_BB;
                        r_busy  <= 1'b1;
                    end else if (i_uart_active) begin
                        r_owner <= OWN_UART;
                        r_busy  <= 1'b1;
                    end
                end
                OWN_BB: begin
                    if (!i_bb_active) begin
                        r_owner <= OWN_NONE;
                        r_busy  <= 1'b0;
                    end
                end
                OWN_UART: begin
                    if (!i_uart_active) begin
                        r_owner <= OWN_NONE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_owner <= OWN_NONE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        o_owner_active = 1'b0;
        o_strobe       = 1'b0;
        o_data         = '0;
        case (r_owner)
            OWN_BB: begin
                o_owner_active = i_bb_active;
                o_strobe       = i_bb_strobe;
                o_data         = i_bb_data;
            end
            OWN_UART: begin
                o_owner_active = i_uart_active;
                o_strobe       = i_uart_strobe;
                o_data         = i_uart_data;
            end
            default: ;
        endcase
    end

    assign o_grant = (r_owner == OWN_NONE) && (i_bb_active || i_uart_active);
    assign o_owner = r_owner;
    assign o_busy  = r_busy;

endmodule

// File: rtl/cfg_frame_sequencer.sv
// Parses header + data word streams from the owning config source and turns
// them into row writes followed by a single commit into the frame memory.
module cfg_frame_sequencer
    import cfg_frame_sequencer_pkg::*;
#(
    parameter int NUM_ROWS   = 16,
    parameter int MAX_FRAMES = 20
)(
    input  logic                  clk,
    input  logic                  resetn,
    cfg_frame_sequencer_if.slave  bus
);

    localparam int ROW_W = row_width(NUM_ROWS);

    owner_t      w_owner;
    logic        w_busy;
    logic        w_grant;
    logic        w_owner_active;
    logic        w_strobe;
    logic [31:0] w_data;

    cfg_src_arbiter u_arbiter (
        .clk            (clk),
        .resetn         (resetn),
        .i_bb_active    (bus.i_bb_active),
        .i_bb_strobe    (bus.i_bb_strobe),
        .i_bb_data      (bus.i_bb_data),
        .i_uart_active  (bus.i_uart_active),
        .i_uart_strobe  (bus.i_uart_strobe),
        .i_uart_data    (bus.i_uart_data),
        .o_owner        (w_owner),
        .o_busy         (w_busy),
        .o_grant        (w_grant),
        .o_owner_active (w_owner_active),
        .o_strobe       (w_strobe),
        .o_data         (w_data)
    );

    state_t           r_state;
    logic [ROW_W-1:0] r_row;
    logic [ROW_W:0]   r_count;
    logic [7:0]       r_col;
    logic [7:0]       r_idx;
    logic [31:0]      r_frame_data;
    logic [ROW_W-1:0] r_frame_row;
    logic             r_frame_we;
    logic [7:0]       r_frame_col;
    logic [7:0]       r_frame_idx;
    logic             r_frame_commit;
    logic             r_cfg_err;

    logic [7:0]  w_hdr_col;
    logic [7:0]  w_hdr_idx;
    logic [15:0] w_hdr_count;
    logic        w_hdr_valid;
    logic        w_last_row;

    assign w_hdr_col   = w_data[HDR_COL_MSB:HDR_COL_LSB];
    assign w_hdr_idx   = w_data[HDR_IDX_MSB:HDR_IDX_LSB];
    assign w_hdr_count = w_data[HDR_CNT_MSB:HDR_CNT_LSB];
    assign w_hdr_valid = (w_hdr_count != 16'd0)
                      && ({16'd0, w_hdr_count} <= $unsigned(NUM_ROWS))
                      && ({24'd0, w_hdr_idx} < $unsigned(MAX_FRAMES));
    assign w_last_row  = ({1'b0, r_row} == (r_count - 1'b1));

    // Losing the owner outside HEADER aborts the frame; that check outranks any strobe.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state        <= ST_IDLE;
            r_row          <= '0;
            r_count        <= '0;
            r_col          <= '0;
            r_idx          <= '0;
            r_frame_data   <= '0;
            r_frame_row    <= '0;
            r_frame_we     <= 1'b0;
            r_frame_col    <= '0;
            r_frame_idx    <= '0;
            r_frame_commit <= 1'b0;
            r_cfg_err      <= 1'b0;
        end else begin
            r_frame_we     <= 1'b0;
            r_frame_commit <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_grant) r_state <= ST_HEADER;
                end
                ST_HEADER: begin
                    if (!w_owner_active) begin
                        r_state <= ST_IDLE;
                    end else if (w_strobe) begin
                        if (w_hdr_valid) begin
                            r_col   <= w_hdr_col;
                            r_idx   <= w_hdr_idx;
                            r_count <= w_hdr_count[ROW_W:0];
                            r_row   <= '0;
                            r_state <= ST_DATA;
                        end else begin
                            r_cfg_err <= 1'b1;
                        end
                    end
                end
                ST_DATA: begin
                    if (!w_owner_active) begin
                        r_cfg_err <= 1'b1;
                        r_state   <= ST_IDLE;
                    end else if (w_strobe) begin
                        r_frame_we   <= 1'b1;
                        r_frame_data <= w_data;
                        r_frame_row  <= r_row;
                        if (w_last_row) begin
                            r_state <= ST_COMMIT;
                        end else begin
                            r_row <= r_row + 1'b1;
                        end
                    end
                end
                ST_COMMIT: begin
                    if (!w_owner_active) begin
                        r_cfg_err <= 1'b1;
                        r_state   <= ST_IDLE;
                    end else begin
                        r_frame_commit <= 1'b1;
                        r_frame_col    <= r_col;
                        r_frame_idx    <= r_idx;
                        if (w_strobe) r_cfg_err <= 1'b1;
                        r_state <= ST_HEADER;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.o_frame_data   = r_frame_data;
    assign bus.o_frame_row    = r_frame_row;
    assign bus.o_frame_we     = r_frame_we;
    assign bus.o_frame_col    = r_frame_col;
    assign bus.o_frame_idx    = r_frame_idx;
    assign bus.o_frame_commit = r_frame_commit;
    assign bus.o_owner        = w_owner;
    assign bus.o_busy         = w_busy;
    assign bus.o_cfg_err      = r_cfg_err;

endmodule

// File: tb/tb_cfg_frame_sequencer.sv
// Directed bench for cfg_frame_sequencer: expected row writes and commits are
// queued as words are issued and matched by a negedge monitor.
module tb_cfg_frame_sequencer;

    typedef struct {
        logic [1:0]  kind;
        logic [31:0] data;
        logic [3:0]  row;
        logic [7:0]  col;
        logic [7:0]  idx;
    } evt_t;

    localparam logic [1:0] EV_WE     = 2'b01;
    localparam logic [1:0] EV_COMMIT = 2'b10;

    logic clk;
    logic resetn;
    int   checks;
    int   failures;
    evt_t sbQueue[$];
    evt_t monEvt;

    cfg_frame_sequencer_if #(.NUM_ROWS(16)) bus();

    cfg_frame_sequencer #(.NUM_ROWS(16), .MAX_FRAMES(20)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%h required=%h", name, actual, expected);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input bit useUart, input logic [31:0] word);
        if (useUart) begin
            bus.i_uart_strobe = 1'b1;
            bus.i_uart_data   = word;
        end else begin
            bus.i_bb_strobe = 1'b1;
            bus.i_bb_data   = word;
        end
        tick(1);
        bus.i_bb_strobe   = 1'b0;
        bus.i_uart_strobe = 1'b0;
    endtask

    task automatic expectWrite(input logic [3:0] row, input logic [31:0] data);
        evt_t e;
        e.kind = EV_WE; e.data = data; e.row = row; e.col = 8'd0; e.idx = 8'd0;
        sbQueue.push_back(e);
    endtask

    task automatic expectCommit(input logic [7:0] col, input logic [7:0] idx);
        evt_t e;
        e.kind = EV_COMMIT; e.data = 32'd0; e.row = 4'd0; e.col = col; e.idx = idx;
        sbQueue.push_back(e);
    endtask

    task automatic doReset();
        resetn = 1'b0;
        bus.i_bb_active   = 1'b0;
        bus.i_bb_strobe   = 1'b0;
        bus.i_bb_data     = 32'd0;
        bus.i_uart_active = 1'b0;
        bus.i_uart_strobe = 1'b0;
        bus.i_uart_data   = 32'd0;
        sbQueue.delete();
        repeat (2) @(posedge clk);
        #1;
        resetn = 1'b1;
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_owner"},   {30'd0, bus.o_owner}, 32'd0);
        checkOutput({tag, "_busy"},    {31'd0, bus.o_busy}, 32'd0);
        checkOutput({tag, "_cfg_err"}, {31'd0, bus.o_cfg_err}, 32'd0);
        checkOutput({tag, "_we"},      {31'd0, bus.o_frame_we}, 32'd0);
        checkOutput({tag, "_commit"},  {31'd0, bus.o_frame_commit}, 32'd0);
        checkOutput({tag, "_data"},    bus.o_frame_data, 32'd0);
        checkOutput({tag, "_row"},     {28'd0, bus.o_frame_row}, 32'd0);
        checkOutput({tag, "_col"},     {24'd0, bus.o_frame_col}, 32'd0);
        checkOutput({tag, "_idx"},     {24'd0, bus.o_frame_idx}, 32'd0);
    endtask

    // Every write or commit pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (resetn && (bus.o_frame_we || bus.o_frame_commit)) begin
            if (sbQueue.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL unexpected_output actual we=%0b commit=%0b row=%0d data=%h required=none",
                         bus.o_frame_we, bus.o_frame_commit, bus.o_frame_row, bus.o_frame_data);
            end else begin
                monEvt = sbQueue.pop_front();
                checkOutput("evt_kind", {30'd0, bus.o_frame_commit, bus.o_frame_we}, {30'd0, monEvt.kind});
                if (monEvt.kind == EV_WE) begin
                    checkOutput("we_data", bus.o_frame_data, monEvt.data);
                    checkOutput("we_row", {28'd0, bus.o_frame_row}, {28'd0, monEvt.row});
                end else begin
                    checkOutput("commit_col", {24'd0, bus.o_frame_col}, {24'd0, monEvt.col});
                    checkOutput("commit_idx", {24'd0, bus.o_frame_idx}, {24'd0, monEvt.idx});
                end
            end
        end
    end

    initial begin
        checks   = 0;
        failures = 0;
        resetn   = 1'b0;
        bus.i_bb_active   = 1'b0;
        bus.i_bb_strobe   = 1'b0;
        bus.i_bb_data     = 32'd0;
        bus.i_uart_active = 1'b0;
        bus.i_uart_strobe = 1'b0;
        bus.i_uart_data   = 32'd0;
        #2;
        checkResetValues("por");
        doReset();

        // Basic bitbang frame of two rows.
        bus.i_bb_active = 1'b1;
        tick(1);
        checkOutput("s1_owner", {30'd0, bus.o_owner}, 32'd1);
        checkOutput("s1_busy", {31'd0, bus.o_busy}, 32'd1);
        applyStimulus(1'b0, 32'h0305_0002);
        expectWrite(4'd0, 32'h1111_1111);
        applyStimulus(1'b0, 32'h1111_1111);
        expectWrite(4'd1, 32'h2222_2222);
        expectCommit(8'd3, 8'd5);
        applyStimulus(1'b0, 32'h2222_2222);
        tick(3);
        checkOutput("s1_drain", sbQueue.size(), 32'd0);
        checkOutput("s1_cfg_err", {31'd0, bus.o_cfg_err}, 32'd0);
        checkOutput("s1_col_hold", {24'd0, bus.o_frame_col}, 32'd3);
        checkOutput("s1_idx_hold", {24'd0, bus.o_frame_idx}, 32'd5);
        bus.i_bb_active = 1'b0;
        tick(1);
        checkOutput("s1_release", {30'd0, bus.o_owner}, 32'd0);
        tick(1);

        // Simultaneous request: bitbang wins, uart locked out until release.
        bus.i_bb_active   = 1'b1;
        bus.i_uart_active = 1'b1;
        tick(1);
        checkOutput("s2_owner_bb", {30'd0, bus.o_owner}, 32'd1);
        applyStimulus(1'b1, 32'h0102_0001);
        applyStimulus(1'b1, 32'h5555_5555);
        tick(2);
        checkOutput("s2_ignored_drain", sbQueue.size(), 32'd0);
        checkOutput("s2_ignored_err", {31'd0, bus.o_cfg_err}, 32'd0);
        bus.i_bb_active = 1'b0;
        tick(1);
        checkOutput("s2_owner_gap", {30'd0, bus.o_owner}, 32'd0);
        tick(1);
        checkOutput("s2_owner_uart", {30'd0, bus.o_owner}, 32'd2);
        applyStimulus(1'b1, 32'h0A01_0001);
        expectWrite(4'd0, 32'hDEAD_BEEF);
        expectCommit(8'h0A, 8'h01);
        applyStimulus(1'b1, 32'hDEAD_BEEF);
        applyStimulus(1'b1, 32'h0B00_0001);
        tick(3);
        checkOutput("s2_drain", sbQueue.size(), 32'd0);
        checkOutput("s2_commit_strobe_err", {31'd0, bus.o_cfg_err}, 32'd1);

        // Out-of-range frame index rejected, sequencer stays in HEADER.
        doReset();
        bus.i_bb_active = 1'b1;
        tick(1);
        applyStimulus(1'b0, 32'h0015_0001);
        tick(2);
        checkOutput("s3_bad_idx_err", {31'd0, bus.o_cfg_err}, 32'd1);
        checkOutput("s3_bad_idx_drain", sbQueue.size(), 32'd0);
        applyStimulus(1'b0, 32'h0113_0001);
        expectWrite(4'd0, 32'hCAFE_F00D);
        expectCommit(8'd1, 8'd19);
        applyStimulus(1'b0, 32'hCAFE_F00D);
        tick(3);
        checkOutput("s3_drain", sbQueue.size(), 32'd0);

        // Uart owner drops mid-frame: abort without commit.
        doReset();
        bus.i_uart_active = 1'b1;
        tick(1);
        checkOutput("s4_owner", {30'd0, bus.o_owner}, 32'd2);
        applyStimulus(1'b1, 32'h0102_0003);
        expectWrite(4'd0, 32'h3333_3333);
        applyStimulus(1'b1, 32'h3333_3333);
        expectWrite(4'd1, 32'h4444_4444);
        applyStimulus(1'b1, 32'h4444_4444);
        bus.i_uart_active = 1'b0;
        tick(1);
        checkOutput("s4_owner_none", {30'd0, bus.o_owner}, 32'd0);
        checkOutput("s4_busy", {31'd0, bus.o_busy}, 32'd0);
        checkOutput("s4_abort_err", {31'd0, bus.o_cfg_err}, 32'd1);
        tick(4);
        checkOutput("s4_drain", sbQueue.size(), 32'd0);

        // Full 16-row frame, then N=17 rejected.
        doReset();
        bus.i_bb_active = 1'b1;
        tick(1);
        applyStimulus(1'b0, 32'h0713_0010);
        for (int i = 0; i < 16; i++) begin
            expectWrite(4'(i), 32'hA000_0000 + 32'(i));
            if (i == 15) expectCommit(8'd7, 8'd19);
            applyStimulus(1'b0, 32'hA000_0000 + 32'(i));
        end
        tick(3);
        checkOutput("s5_drain", sbQueue.size(), 32'd0);
        checkOutput("s5_cfg_err", {31'd0, bus.o_cfg_err}, 32'd0);
        applyStimulus(1'b0, 32'h0700_0011);
        tick(2);
        checkOutput("s5_n17_err", {31'd0, bus.o_cfg_err}, 32'd1);
        checkOutput("s5_n17_drain", sbQueue.size(), 32'd0);

        // Reset mid-frame discards the partial frame.
        doReset();
        bus.i_bb_active = 1'b1;
        tick(1);
        applyStimulus(1'b0, 32'h0203_0002);
        expectWrite(4'd0, 32'h5A5A_5A5A);
        applyStimulus(1'b0, 32'h5A5A_5A5A);
        tick(1);
        checkOutput("s6_pre_drain", sbQueue.size(), 32'd0);
        resetn = 1'b0;
        bus.i_bb_active = 1'b0;
        #2;
        checkResetValues("s6_rst");
        repeat (2) @(posedge clk);
        #1;
        resetn = 1'b1;
        tick(5);
        checkOutput("s6_no_commit", sbQueue.size(), 32'd0);
        checkOutput("s6_owner", {30'd0, bus.o_owner}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
